// File: rtl/up_bus_master.sv
// Byte-handshake master for the motion-system uP bus: accepts one command,
// serialises it little-endian, collects the data/status reply and waits for ack.
module up_bus_master #(
  parameter int DATA_BYTES     = 4,
  parameter int SETUP_CYCLES   = 3,
  parameter int TIMEOUT_CYCLES = 1000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [7:0]              cmd_command,
  input  logic [7:0]              cmd_address,
  input  logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    rsp_valid,
  output logic [8*DATA_BYTES-1:0] rsp_data,
  output logic [8*DATA_BYTES-1:0] rsp_status,
  output logic                    rsp_timeout,
  output logic                    rsp_fault,
  output logic                    uP_start,
  output logic                    uP_handshake_1,
  output logic                    uP_RW,
  output logic [7:0]              uP_data_out,
  output logic                    uP_data_oe,
  input  logic [7:0]              uP_data_in,
  input  logic                    uP_handshake_2,
  input  logic                    uP_ack,
  input  logic                    uP_nFault
);

  localparam int W       = 8 * DATA_BYTES;
  localparam int TXW     = 8 * (DATA_BYTES + 2);
  localparam int RXW     = 16 * DATA_BYTES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > SETUP_CYCLES) ? TIMEOUT_CYCLES : SETUP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int IDX_W   = $clog2(2 * DATA_BYTES + 1);

  localparam logic [CNT_W-1:0] SETUP_LAST   = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] W_LAST       = IDX_W'(DATA_BYTES + 1);
  localparam logic [IDX_W-1:0] R_LAST       = IDX_W'(2 * DATA_BYTES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_W_SETUP, S_W_HS1, S_W_REL,
    S_R_WAIT, S_R_ACK, S_R_REL, S_END, S_DONE, S_ABORT
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic [TXW-1:0]     tx_q;
  logic [RXW-1:0]     rx_q;
  logic               run_q;
  logic [SYNC_STAGES-1:0] hs2_sync, ack_sync, nfault_sync;
  logic               hs2_s, ack_s, nfault_s;
  logic               setup_done, timed_out;

  // NOTE: nFault synchroniser resets to 1 (no fault) so reset release never reports a fault.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hs2_sync    <= '0;
      ack_sync    <= '0;
      nfault_sync <= '1;
    end else begin
      hs2_sync    <= {hs2_sync[SYNC_STAGES-2:0], uP_handshake_2};
      ack_sync    <= {ack_sync[SYNC_STAGES-2:0], uP_ack};
      nfault_sync <= {nfault_sync[SYNC_STAGES-2:0], uP_nFault};
    end
  end

  assign hs2_s      = hs2_sync[SYNC_STAGES-1];
  assign ack_s      = ack_sync[SYNC_STAGES-1];
  assign nfault_s   = nfault_sync[SYNC_STAGES-1];
  assign setup_done = (cnt_q == SETUP_LAST);
  assign timed_out  = (cnt_q == TIMEOUT_LAST);

  // run_q keeps cmd_ready low while reset is asserted.
  assign cmd_ready  = (state_q == S_IDLE) && run_q;
  assign uP_data_oe = uP_RW;
  assign uP_data_out = uP_RW ? tx_q[7:0] : 8'h00;

  // NOTE: state_d gets its default before the case so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (cmd_valid && cmd_ready) state_d = S_START;
      S_START:   if (setup_done) state_d = S_W_SETUP;
      S_W_SETUP: if (setup_done) state_d = S_W_HS1;
      S_W_HS1:   if (hs2_s) state_d = S_W_REL;
                 else if (timed_out) state_d = S_ABORT;
      S_W_REL:   if (!hs2_s) state_d = (idx_q == W_LAST) ? S_R_WAIT : S_W_SETUP;
                 else if (timed_out) state_d = S_ABORT;
      S_R_WAIT:  if (hs2_s) state_d = S_R_ACK;
                 else if (timed_out) state_d = S_ABORT;
      S_R_ACK:   if (!hs2_s) state_d = S_R_REL;
                 else if (timed_out) state_d = S_ABORT;
      S_R_REL:   if (setup_done) state_d = (idx_q == R_LAST) ? S_END : S_R_WAIT;
      S_END:     if (ack_s) state_d = S_DONE;
                 else if (timed_out) state_d = S_ABORT;
      S_DONE,
      S_ABORT:   state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  // NOTE: bus strobes are registered from state_d so they never glitch on state decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      run_q          <= 1'b0;
      cnt_q          <= '0;
      idx_q          <= '0;
      tx_q           <= '0;
      rx_q           <= '0;
      uP_start       <= 1'b0;
      uP_RW          <= 1'b0;
      uP_handshake_1 <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      rsp_status     <= '0;
      rsp_timeout    <= 1'b0;
      rsp_fault      <= 1'b0;
    end else begin
      state_q <= state_d;
      run_q   <= 1'b1;
      cnt_q   <= (state_d != state_q || state_q == S_IDLE) ? '0 : cnt_q + CNT_W'(1);

      uP_start       <= state_d inside {S_START, S_W_SETUP, S_W_HS1, S_W_REL,
                                        S_R_WAIT, S_R_ACK, S_R_REL, S_END};
      uP_RW          <= state_d inside {S_W_SETUP, S_W_HS1, S_W_REL};
      uP_handshake_1 <= state_d inside {S_W_HS1, S_R_ACK};
      rsp_valid      <= state_d inside {S_DONE, S_ABORT};

      if (state_q == S_IDLE && state_d == S_START) begin
        tx_q  <= {cmd_data, cmd_address, cmd_command};
        idx_q <= '0;
      end
      if (state_q == S_W_REL && state_d == S_W_SETUP) begin
        tx_q  <= tx_q >> 8;
        idx_q <= idx_q + IDX_W'(1);
      end
      if (state_q == S_W_REL && state_d == S_R_WAIT) idx_q <= '0;
      // Reply bytes enter at the top so byte 0 ends up in bits [7:0].
      if (state_q == S_R_WAIT && state_d == S_R_ACK) rx_q <= {uP_data_in, rx_q[RXW-1:8]};
      if (state_q == S_R_REL && state_d == S_R_WAIT) idx_q <= idx_q + IDX_W'(1);

      if (state_d == S_DONE) begin
        rsp_data    <= rx_q[W-1:0];
        rsp_status  <= rx_q[RXW-1:W];
        rsp_timeout <= 1'b0;
        rsp_fault   <= ~nfault_s;
      end
      if (state_d == S_ABORT) begin
        rsp_data    <= '0;
        rsp_status  <= '0;
        rsp_timeout <= 1'b1;
        rsp_fault   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_up_bus_master.sv
// Directed bench for up_bus_master: reactive slave model shared by a 4-byte and a
// 2-byte master, with expected responses queued at issue and popped on rsp_valid.
module tb_up_bus_master;

  typedef struct packed {
    logic [31:0] data;
    logic [31:0] status;
    logic        timeout;
    logic        fault;
  } rsp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sel = 1'b0;
  logic        a_valid = 1'b0, b_valid = 1'b0;
  logic [7:0]  cmd_command = '0, cmd_address = '0;
  logic [31:0] cmd_data = '0;

  logic        a_ready, a_rsp_valid, a_rsp_timeout, a_rsp_fault;
  logic [31:0] a_rsp_data, a_rsp_status;
  logic        a_start, a_hs1, a_rw, a_oe;
  logic [7:0]  a_dout;
  logic        b_ready, b_rsp_valid, b_rsp_timeout, b_rsp_fault;
  logic [15:0] b_rsp_data, b_rsp_status;
  logic        b_start, b_hs1, b_rw, b_oe;
  logic [7:0]  b_dout;

  logic        s_hs2 = 1'b0, s_ack = 1'b0, s_nfault = 1'b1;
  logic [7:0]  s_data_in = '0;

  int vectors = 0, miscompares = 0, rsp_count = 0;
  rsp_t exp_q[$];

  always #5 clk = ~clk;

  up_bus_master #(.DATA_BYTES(4), .SETUP_CYCLES(3), .TIMEOUT_CYCLES(20), .SYNC_STAGES(2)) dut_a (
    .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
    .cmd_command(cmd_command), .cmd_address(cmd_address), .cmd_data(cmd_data),
    .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_status(a_rsp_status),
    .rsp_timeout(a_rsp_timeout), .rsp_fault(a_rsp_fault),
    .uP_start(a_start), .uP_handshake_1(a_hs1), .uP_RW(a_rw), .uP_data_out(a_dout),
    .uP_data_oe(a_oe), .uP_data_in(s_data_in), .uP_handshake_2(s_hs2),
    .uP_ack(s_ack), .uP_nFault(s_nfault));

  up_bus_master #(.DATA_BYTES(2), .SETUP_CYCLES(3), .TIMEOUT_CYCLES(1000), .SYNC_STAGES(2)) dut_b (
    .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
    .cmd_command(cmd_command), .cmd_address(cmd_address), .cmd_data(cmd_data[15:0]),
    .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_status(b_rsp_status),
    .rsp_timeout(b_rsp_timeout), .rsp_fault(b_rsp_fault),
    .uP_start(b_start), .uP_handshake_1(b_hs1), .uP_RW(b_rw), .uP_data_out(b_dout),
    .uP_data_oe(b_oe), .uP_data_in(s_data_in), .uP_handshake_2(s_hs2),
    .uP_ack(s_ack), .uP_nFault(s_nfault));

  // Slave model follows whichever master sel points at; the other one stays idle.
  wire       m_start = sel ? b_start : a_start;
  wire       m_hs1   = sel ? b_hs1   : a_hs1;
  wire       m_rw    = sel ? b_rw    : a_rw;
  wire [7:0] m_dout  = sel ? b_dout  : a_dout;
  wire       m_ready = sel ? b_ready : a_ready;
  wire [3:0] nwrite  = sel ? 4'd4 : 4'd6;
  wire [3:0] nread   = sel ? 4'd4 : 4'd8;

  logic [7:0] reply [8];
  logic [7:0] wbytes [8];
  logic       wrw [8];
  logic [3:0] wcnt = '0, rcnt = '0;
  logic       hs1_p = 1'b0;
  logic       cfg_nfault = 1'b1;
  int         stall_idx = 99;

  always @(posedge clk) begin
    hs1_p <= m_hs1;
    if (!m_start) begin
      s_hs2 <= 1'b0; s_ack <= 1'b0; s_nfault <= 1'b1; wcnt <= '0; rcnt <= '0;
    end else if (wcnt < nwrite || m_rw) begin
      if (m_hs1 && !hs1_p && wcnt < nwrite) begin
        wbytes[wcnt[2:0]] <= m_dout;
        wrw[wcnt[2:0]]    <= m_rw;
        wcnt              <= wcnt + 4'd1;
        if (int'(wcnt) != stall_idx) s_hs2 <= 1'b1;
      end
      if (!m_hs1 && hs1_p) s_hs2 <= 1'b0;
    end else begin
      if (m_hs1 && !hs1_p) begin
        s_hs2 <= 1'b0;
        rcnt  <= rcnt + 4'd1;
      end else if (!m_hs1 && !s_hs2 && rcnt < nread) begin
        s_data_in <= reply[rcnt[2:0]];
        s_hs2     <= 1'b1;
      end else if (!m_hs1 && !s_hs2 && rcnt == nread) begin
        s_ack    <= 1'b1;
        s_nfault <= cfg_nfault;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic compare_rsp(input string tag, input rsp_t got);
    rsp_t e;
    rsp_count++;
    check({tag, "_expected"}, 64'(exp_q.size() != 0), 64'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_data"},    64'(got.data),    64'(e.data));
      check({tag, "_status"},  64'(got.status),  64'(e.status));
      check({tag, "_timeout"}, 64'(got.timeout), 64'(e.timeout));
      check({tag, "_fault"},   64'(got.fault),   64'(e.fault));
    end
  endtask

  always @(negedge clk) begin
    if (a_rsp_valid)
      compare_rsp("rsp_a", {a_rsp_data, a_rsp_status, a_rsp_timeout, a_rsp_fault});
    if (b_rsp_valid)
      compare_rsp("rsp_b", {16'h0, b_rsp_data, 16'h0, b_rsp_status, b_rsp_timeout, b_rsp_fault});
  end

  task automatic set_reply(input logic [63:0] bytes);
    for (int i = 0; i < 8; i++) reply[i] = bytes[8*i +: 8];
  endtask

  task automatic push_exp(input logic [31:0] d, input logic [31:0] s, input logic t, input logic f);
    rsp_t e;
    e.data = d; e.status = s; e.timeout = t; e.fault = f;
    exp_q.push_back(e);
  endtask

  task automatic issue(input logic [7:0] c, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    @(negedge clk);
    while (!m_ready && n < 100) begin @(negedge clk); n++; end
    check("cmd_ready_idle", 64'(m_ready), 64'd1);
    cmd_command = c; cmd_address = a; cmd_data = d;
    if (sel) b_valid = 1'b1; else a_valid = 1'b1;
    @(negedge clk);
    a_valid = 1'b0; b_valid = 1'b0;
    check("cmd_ready_busy", 64'(m_ready), 64'd0);
  endtask

  task automatic wait_rsp(input int target);
    int n = 0;
    while (rsp_count < target && n < 3000) begin @(negedge clk); n++; end
    repeat (4) @(negedge clk);
    check("rsp_count", 64'(rsp_count), 64'(target));
  endtask

  initial begin
    logic [7:0] exp_wr [6] = '{8'h01, 8'h12, 8'h34, 8'h12, 8'hA5, 8'hA5};
    logic [31:0] exp_b_wr;
    logic all_rw;
    int n_rsp = 0;
    int n;

    // Reset state.
    #1 reset = 1'b0;
    #1;
    check("reset_bus_a", 64'({a_start, a_hs1, a_rw, a_oe, a_dout, a_rsp_valid, a_ready}), 64'd0);
    check("reset_rsp_a", 64'({a_rsp_data, a_rsp_status, a_rsp_timeout, a_rsp_fault}), 64'd0);
    check("reset_bus_b", 64'({b_start, b_hs1, b_rw, b_oe, b_dout, b_rsp_valid, b_ready}), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;

    // Write register.
    set_reply(64'h0000_0001_DDCC_BBAA);
    push_exp(32'hDDCC_BBAA, 32'h0000_0001, 1'b0, 1'b0);
    issue(8'h01, 8'h12, 32'hA5A5_1234);
    n_rsp++; wait_rsp(n_rsp);
    all_rw = 1'b1;
    for (int i = 0; i < 6; i++) begin
      check($sformatf("wr_byte%0d", i), 64'(wbytes[i]), 64'(exp_wr[i]));
      all_rw &= wrw[i];
    end
    check("wr_rw_at_hs1", 64'(all_rw), 64'd1);

    // Read register.
    set_reply(64'h8000_0000_1234_5678);
    push_exp(32'h1234_5678, 32'h8000_0000, 1'b0, 1'b0);
    issue(8'h00, 8'h05, 32'h0);
    n_rsp++; wait_rsp(n_rsp);
    check("rd_cmd_byte", 64'(wbytes[0]), 64'h00);
    check("rd_addr_byte", 64'(wbytes[1]), 64'h05);

    // Fault at ack, then a clean transaction clears it.
    cfg_nfault = 1'b0;
    set_reply(64'h0000_00FF_CAFE_F00D);
    push_exp(32'hCAFE_F00D, 32'h0000_00FF, 1'b0, 1'b1);
    issue(8'h00, 8'h21, 32'h0);
    n_rsp++; wait_rsp(n_rsp);
    cfg_nfault = 1'b1;
    set_reply(64'h0102_0304_0506_0708);
    push_exp(32'h0506_0708, 32'h0102_0304, 1'b0, 1'b0);
    issue(8'h00, 8'h22, 32'h0);
    n_rsp++; wait_rsp(n_rsp);

    // Timeout: slave ignores the strobe for byte 2.
    stall_idx = 2;
    push_exp(32'h0, 32'h0, 1'b1, 1'b0);
    issue(8'h01, 8'h33, 32'h1111_2222);
    n = 0;
    while (wcnt != 4'd3 && n < 200) begin @(negedge clk); n++; end
    check("to_byte2_strobe", 64'(wcnt), 64'd3);
    n = 0;
    while (!a_rsp_valid && n < 40) begin @(negedge clk); n++; end
    check("to_latency_in_range", 64'((n + 1) >= 20 && (n + 1) <= 24), 64'd1);
    check("to_bus_released", 64'({a_start, a_hs1, a_rw, a_oe, a_dout}), 64'd0);
    @(negedge clk);
    check("to_ready_next", 64'(a_ready), 64'd1);
    stall_idx = 99;
    n_rsp++; wait_rsp(n_rsp);

    // Reset in the middle of the reply packet: no response may appear.
    set_reply(64'h8000_0000_1234_5678);
    issue(8'h00, 8'h44, 32'h0);
    n = 0;
    while (rcnt != 4'd4 && n < 500) begin @(negedge clk); n++; end
    check("mid_reset_reached", 64'(rcnt), 64'd4);
    #2 reset = 1'b0;
    #1;
    check("mid_reset_bus", 64'({a_start, a_hs1, a_rw, a_oe, a_dout, a_rsp_valid}), 64'd0);
    check("mid_reset_rsp", 64'({a_rsp_data, a_rsp_timeout, a_rsp_fault}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    wait_rsp(n_rsp);

    // Fresh read after reset.
    set_reply(64'h0BAD_BEEF_89AB_CDEF);
    push_exp(32'h89AB_CDEF, 32'h0BAD_BEEF, 1'b0, 1'b0);
    issue(8'h00, 8'h55, 32'h0);
    n_rsp++; wait_rsp(n_rsp);

    // Two-byte build.
    sel = 1'b1;
    set_reply(64'h0000_0000_4433_2211);
    push_exp(32'h0000_2211, 32'h0000_4433, 1'b0, 1'b0);
    issue(8'h01, 8'h34, 32'h0000_BEEF);
    n_rsp++; wait_rsp(n_rsp);
    exp_b_wr = 32'hBEEF_3401;
    for (int i = 0; i < 4; i++)
      check($sformatf("b_wr_byte%0d", i), 64'(wbytes[i]), 64'(exp_b_wr[8*i +: 8]));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
